m_muxn_reg: RTL and testbench



---
 rtl/slipstream_mux_pkg.sv | 27 ++
 rtl/m_muxn_sel.sv | 41 ++++
 rtl/m_muxn_reg.sv | 80 ++++++++
 tb/tb_m_muxn_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/slipstream_mux_pkg.sv
// Shared helpers for the Slipstream select muxes: conflict-mode codes,
// popcount and lowest-set-bit index over selects of up to 16 bits.
package slipstream_mux_pkg;

  localparam int MODE_OR   = 0;
  localparam int MODE_PRIO = 1;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] onehot_to_index(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/m_muxn_sel.sv
// Combinational N-way selector: one-hot SEL picks channel k+1, empty SEL
// picks channel 0; multi-hot either ORs the picks or takes the lowest.
module m_muxn_sel
  import slipstream_mux_pkg::*;
#(
  parameter int N        = 3,
  parameter int WIDTH    = 1,
  parameter int PRIORITY = MODE_OR
) (
  input  logic [N*WIDTH-1:0]   d_i,
  input  logic [N-2:0]         sel_i,
  output logic [WIDTH-1:0]     val_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  logic [3:0] lo;
  logic [4:0] pc;

  always_comb begin
    lo    = onehot_to_index(16'(sel_i));
    pc    = popcount(16'(sel_i));
    val_o = '0;
    idx_o = '0;
    if (pc != 5'd0) begin
      idx_o = IW'(lo + 4'd1);
    end
    // Legacy OR-combine never includes the default channel.
    if (PRIORITY == MODE_OR && pc > 5'd1) begin
      for (int k = 0; k < N - 1; k++) begin
        if (sel_i[k]) val_o = val_o | d_i[(k+1)*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (IW'(k) == idx_o) val_o = d_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/m_muxn_reg.sv
// Registered N-way select with load enable, sticky select-conflict flag
// and an auto-scan counter that steps through the channels on STEP.
module m_muxn_reg
  import slipstream_mux_pkg::*;
#(
  parameter int N        = 3,
  parameter int WIDTH    = 1,
  parameter int PRIORITY = MODE_OR
) (
  input  logic                 MasterClock,
  input  logic                 RESETL,
  input  logic [N*WIDTH-1:0]   D,
  input  logic [N-2:0]         SEL,
  input  logic                 LOAD,
  input  logic                 AUTO,
  input  logic                 STEP,
  input  logic                 CLR,
  output logic [WIDTH-1:0]     Z,
  output logic [$clog2(N)-1:0] CURSEL,
  output logic                 CONFLICT
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] CNT_MAX = IW'(N - 1);

  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             conflict_q, conflict_d;

  logic [WIDTH-1:0] man_val, auto_val, cur_val;
  logic [IW-1:0]    man_idx;

  m_muxn_sel #(
    .N        (N),
    .WIDTH    (WIDTH),
    .PRIORITY (PRIORITY)
  ) u_sel (
    .d_i   (D),
    .sel_i (SEL),
    .val_o (man_val),
    .idx_o (man_idx)
  );

  always_comb begin
    auto_val = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == cnt_q) auto_val = D[k*WIDTH +: WIDTH];
    end
    cur_val = AUTO ? auto_val : man_val;
    CURSEL  = AUTO ? cnt_q : man_idx;
  end

  // Explicit wrap keeps non-power-of-two N from ever reaching index N.
  always_comb begin
    cnt_d = cnt_q;
    if (AUTO && STEP) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
    z_d        = LOAD ? cur_val : z_q;
    conflict_d = conflict_q;
    if (CLR) conflict_d = 1'b0;
    if (LOAD && !AUTO && popcount(16'(SEL)) > 5'd1) conflict_d = 1'b1;
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      cnt_q      <= '0;
      z_q        <= '0;
      conflict_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      z_q        <= z_d;
      conflict_q <= conflict_d;
    end
  end

  assign Z        = z_q;
  assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_m_muxn_reg.sv
// Directed bench: two N=4/WIDTH=8 instances (OR and priority mode) share
// stimulus; an N=3/WIDTH=8 instance exercises auto-scan and reset.
module tb_m_muxn_reg;

  logic clk;
  logic rst_n;

  logic [31:0] d4;
  logic [2:0]  sel4;
  logic        load4, auto4, step4, clr4;
  logic [7:0]  z_or, z_pr;
  logic [1:0]  cs_or, cs_pr;
  logic        cf_or, cf_pr;

  logic [23:0] d3;
  logic [1:0]  sel3;
  logic        load3, auto3, step3, clr3;
  logic [7:0]  z3;
  logic [1:0]  cs3;
  logic        cf3;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  m_muxn_reg #(.N(4), .WIDTH(8), .PRIORITY(0)) u_or (
    .MasterClock(clk), .RESETL(rst_n), .D(d4), .SEL(sel4), .LOAD(load4),
    .AUTO(auto4), .STEP(step4), .CLR(clr4), .Z(z_or), .CURSEL(cs_or),
    .CONFLICT(cf_or)
  );

  m_muxn_reg #(.N(4), .WIDTH(8), .PRIORITY(1)) u_pr (
    .MasterClock(clk), .RESETL(rst_n), .D(d4), .SEL(sel4), .LOAD(load4),
    .AUTO(auto4), .STEP(step4), .CLR(clr4), .Z(z_pr), .CURSEL(cs_pr),
    .CONFLICT(cf_pr)
  );

  m_muxn_reg #(.N(3), .WIDTH(8), .PRIORITY(0)) u_n3 (
    .MasterClock(clk), .RESETL(rst_n), .D(d3), .SEL(sel3), .LOAD(load3),
    .AUTO(auto3), .STEP(step3), .CLR(clr3), .Z(z3), .CURSEL(cs3),
    .CONFLICT(cf3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    d4 = 32'h44_33_22_11; sel4 = 3'b000;
    load4 = 0; auto4 = 0; step4 = 0; clr4 = 0;
    d3 = 24'hCC_BB_AA; sel3 = 2'b00;
    load3 = 0; auto3 = 0; step3 = 0; clr3 = 0;

    #3;
    chk("rst_z", {24'd0, z_or}, 32'h00);
    chk("rst_conflict", {31'd0, cf_or}, 32'h0);
    chk("rst_cursel", {30'd0, cs_or}, 32'h0);
    #4 rst_n = 1'b1;

    load4 = 1;
    tick();
    chk("load_ch0_z", {24'd0, z_or}, 32'h11);

    sel4 = 3'b010;
    #1 chk("onehot_cursel", {30'd0, cs_or}, 32'h2);
    tick();
    chk("onehot_z", {24'd0, z_or}, 32'h33);
    load4 = 0; sel4 = 3'b100;
    tick();
    chk("hold_z", {24'd0, z_or}, 32'h33);
    chk("hold_cursel", {30'd0, cs_or}, 32'h3);

    d4 = 32'h0F_F0_81_00; sel4 = 3'b011; load4 = 1;
    #1 chk("conf_cursel", {30'd0, cs_or}, 32'h1);
    tick();
    chk("conf_or_z", {24'd0, z_or}, 32'hF1);
    chk("conf_or_flag", {31'd0, cf_or}, 32'h1);
    chk("conf_pr_z", {24'd0, z_pr}, 32'h81);
    chk("conf_pr_flag", {31'd0, cf_pr}, 32'h1);
    load4 = 0; clr4 = 1;
    tick();
    chk("clr_flag", {31'd0, cf_or}, 32'h0);
    load4 = 1;
    tick();
    chk("set_beats_clr", {31'd0, cf_or}, 32'h1);
    load4 = 0; clr4 = 0;

    auto3 = 1;
    #1 chk("scan0", {30'd0, cs3}, 32'h0);
    step3 = 1;
    tick(); chk("scan1", {30'd0, cs3}, 32'h1);
    tick(); chk("scan2", {30'd0, cs3}, 32'h2);
    tick(); chk("scan_wrap", {30'd0, cs3}, 32'h0);
    tick(); chk("scan1b", {30'd0, cs3}, 32'h1);
    tick(); chk("scan2b", {30'd0, cs3}, 32'h2);
    load3 = 1;
    tick();
    chk("auto_load_precnt", {24'd0, z3}, 32'hCC);
    chk("auto_after_step", {30'd0, cs3}, 32'h0);
    load3 = 0;
    tick();
    chk("scan_to1", {30'd0, cs3}, 32'h1);

    auto3 = 0;
    tick(); tick();
    chk("manual_cursel", {30'd0, cs3}, 32'h0);
    step3 = 0; auto3 = 1;
    #1 chk("cnt_held", {30'd0, cs3}, 32'h1);
    step3 = 1;
    tick();
    step3 = 0;
    chk("scan_to2", {30'd0, cs3}, 32'h2);

    auto3 = 0; sel3 = 2'b11; load3 = 1;
    tick();
    chk("n3_conf_z", {24'd0, z3}, 32'hFF);
    chk("n3_conf_flag", {31'd0, cf3}, 32'h1);
    load3 = 0; sel3 = 2'b00; auto3 = 1;
    #1 chk("pre_rst_cursel", {30'd0, cs3}, 32'h2);

    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_z", {24'd0, z3}, 32'h0);
    chk("mid_rst_flag", {31'd0, cf3}, 32'h0);
    chk("mid_rst_cnt", {30'd0, cs3}, 32'h0);
    chk("mid_rst_z4", {24'd0, z_or}, 32'h0);

    #10 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
